// File: rtl/pci_arbiter.sv
// -----------------------------------------------------------------------------
// pci_arbiter
//
// Central PCI bus arbiter. Shares one AD/CBE/FRAME#/IRDY# bus among
// NUM_MASTERS initiators through active-low REQ#/GNT# pairs. Arbitration is
// round-robin, starting the search one past the most recently granted master.
// FRAME# and IRDY# are watched to track ownership. Grants never overlap, and
// every hand-over between masters has at least one cycle with all GNT# high.
//
// Optional feature (compile-time macro PCI_ARB_GNT_TIMEOUT_EN):
//   Defined   - a granted master that leaves the bus idle for GNT_TIMEOUT
//               edges loses its grant. o_timeout_stb pulses for one cycle and
//               the master drops to lowest priority.
//   Undefined - no counter. o_timeout_stb is tied low, and a granted master may
//               keep an unused grant indefinitely.
//
// Parameters:
//   NUM_MASTERS  number of REQ#/GNT# pairs (2..8)
//   OWNER_W      width of o_owner, >= clog2(NUM_MASTERS)
//   GNT_TIMEOUT  idle edges allowed before an unused grant is revoked
//
// Ports:
//   i_clk          bus clock; all logic is on the rising edge
//   i_rst          synchronous, active-high reset
//   i_req          per-master request, active-low (bit i = master i)
//   i_frame        PCI FRAME#, active-low
//   i_irdy         PCI IRDY#, active-low
//   o_gnt          per-master grant, active-low; at most one bit low
//   o_owner        index of the granted/owning master
//   o_owner_valid  high while o_owner is meaningful (GRANT or BUSY)
//   o_timeout_stb  one-cycle pulse when a grant is revoked for non-use
// -----------------------------------------------------------------------------
module pci_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_frame,
  input  logic                   i_irdy,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [OWNER_W-1:0]     o_owner,
  output logic                   o_owner_valid,
  output logic                   o_timeout_stb
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  // Reject illegal configurations at elaboration time.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || OWNER_W < IDX_W || GNT_TIMEOUT < 1)
  begin : g_bad_params
    $error("pci_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no owner, all grants high
    ST_GRANT = 2'd1,  // owner granted, waiting for FRAME#
    ST_BUSY  = 2'd2   // owner's transaction in progress
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state (every output comes straight from a flop)
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [OWNER_W-1:0]     r_owner;
  logic                   r_owner_valid;
  logic [OWNER_W-1:0]     r_last;

  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] w_gnt_nxt;
  logic [OWNER_W-1:0]     w_owner_nxt;
  logic                   w_owner_valid_nxt;
  logic [OWNER_W-1:0]     w_last_nxt;

`ifdef PCI_ARB_GNT_TIMEOUT_EN
  localparam int                 CNT_W     = $clog2(GNT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   TMO_LIMIT = CNT_W'(GNT_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_stb;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout_stb_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Decoded bus conditions
  // ---------------------------------------------------------------------------
  logic                   w_bidle;
  logic [IDX_W-1:0]       w_owner_idx;
  logic [NUM_MASTERS-1:0] w_owner_mask;
  logic                   w_owner_req;     // owner still requesting
  logic                   w_owner_gnt;     // owner's GNT# still driven low
  logic                   w_other_req;     // someone else wants the bus

  assign w_bidle      = i_frame & i_irdy;
  assign w_owner_idx  = IDX_W'(r_owner);
  assign w_owner_mask = NUM_MASTERS'(1) << w_owner_idx;
  assign w_owner_req  = ~i_req[w_owner_idx];
  assign w_owner_gnt  = ~r_gnt[w_owner_idx];
  assign w_other_req  = |(~i_req & ~w_owner_mask);

  // ---------------------------------------------------------------------------
  // Round-robin winner: the first low REQ# at r_last+1, r_last+2, ... (mod N).
  // The loop runs from the farthest candidate to the nearest. The nearest
  // requester is therefore the last to write the result, and it wins.
  // ---------------------------------------------------------------------------
  logic                   w_win_found;
  logic [IDX_W-1:0]       w_win_idx;
  logic [IDX_W-1:0]       w_cand;
  logic [NUM_MASTERS-1:0] w_win_gnt;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // value first. Otherwise a path that skips the assignment infers a latch.
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_cand = IDX_W'((int'(r_last) + i) % NUM_MASTERS);
      if (!i_req[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_win_gnt = ~(NUM_MASTERS'(1) << w_win_idx);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_gnt_nxt         = r_gnt;
    w_owner_nxt       = r_owner;
    w_owner_valid_nxt = r_owner_valid;
    w_last_nxt        = r_last;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
    w_cnt_nxt         = r_cnt;
    w_timeout_stb_nxt = 1'b0;
`endif

    unique case (r_state)
      ST_IDLE: begin
        w_gnt_nxt         = '1;
        w_owner_valid_nxt = 1'b0;
        if (w_win_found) begin
          w_state_nxt       = ST_GRANT;
          w_gnt_nxt         = w_win_gnt;
          w_owner_nxt       = OWNER_W'(w_win_idx);
          w_owner_valid_nxt = 1'b1;
          w_last_nxt        = OWNER_W'(w_win_idx);
`ifdef PCI_ARB_GNT_TIMEOUT_EN
          w_cnt_nxt         = '0;
`endif
        end
      end

      ST_GRANT: begin
        // If FRAME# is low, take it even when the request is also being
        // withdrawn on this edge.
        if (!i_frame) begin
          w_state_nxt = ST_BUSY;
        end else if (!w_owner_req) begin
          w_state_nxt       = ST_IDLE;
          w_gnt_nxt         = '1;
          w_owner_valid_nxt = 1'b0;
        end
`ifdef PCI_ARB_GNT_TIMEOUT_EN
        else if (r_cnt == TMO_LIMIT) begin
          w_state_nxt       = ST_IDLE;
          w_gnt_nxt         = '1;
          w_owner_valid_nxt = 1'b0;
          w_timeout_stb_nxt = 1'b1;
          w_last_nxt        = r_owner;   // offender drops to lowest priority
        end else if (w_bidle) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end

      ST_BUSY: begin
        if (w_bidle) begin
          // Back-to-back transfers stay with the owner only when it is
          // uncontested and still holds the grant.
          if (w_owner_gnt && w_owner_req && !w_other_req) begin
            w_state_nxt = ST_GRANT;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_state_nxt       = ST_IDLE;
            w_gnt_nxt         = '1;
            w_owner_valid_nxt = 1'b0;
          end
        end else if (w_owner_gnt && (w_other_req || !w_owner_req)) begin
          // Remove GNT# early. The owner keeps the bus until its current
          // transaction ends, and OWNER stays valid until then.
          w_gnt_nxt = '1;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_gnt_nxt         = '1;
        w_owner_valid_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: flops use non-blocking assignments. Every register then samples
    // the pre-edge values, whatever order the statements are written in.
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_gnt         <= '1;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_last        <= OWNER_W'(NUM_MASTERS - 1);
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_stb <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_owner       <= w_owner_nxt;
      r_owner_valid <= w_owner_valid_nxt;
      r_last        <= w_last_nxt;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      r_cnt         <= w_cnt_nxt;
      r_timeout_stb <= w_timeout_stb_nxt;
`endif
    end
  end

  assign o_gnt         = r_gnt;
  assign o_owner       = r_owner;
  assign o_owner_valid = r_owner_valid;
`ifdef PCI_ARB_GNT_TIMEOUT_EN
  assign o_timeout_stb = r_timeout_stb;
`else
  assign o_timeout_stb = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(~o_gnt));

  // A low grant either stays on the same master or goes all-high first.
  a_handover_gap : assert property (@(posedge i_clk) disable iff (i_rst)
    (o_gnt != '1) |=> (o_gnt == '1 || o_gnt == $past(o_gnt)));

  a_gnt_has_owner : assert property (@(posedge i_clk) disable iff (i_rst)
    (o_gnt != '1) |-> o_owner_valid);

`ifdef PCI_ARB_GNT_TIMEOUT_EN
  a_stb_pulse : assert property (@(posedge i_clk) disable iff (i_rst)
    o_timeout_stb |=> !o_timeout_stb);
`endif

endmodule

// File: tb/tb_pci_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pci_arbiter
//
// Self-checking bench for pci_arbiter. The directed scenarios check against
// hand-derived constants. A randomized phase checks every cycle against a
// rule-level model of the arbiter. That model tracks who owns the bus, whether
// the owner's grant is still asserted, and whether the owner is mid-transaction.
// -----------------------------------------------------------------------------
module tb_pci_arbiter;

  localparam int NM  = 4;
  localparam int OW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] req;
  logic          frame;
  logic          irdy;
  logic [NM-1:0] gnt;
  logic [OW-1:0] owner;
  logic          owner_valid;
  logic          timeout_stb;

  pci_arbiter #(
    .NUM_MASTERS (NM),
    .OWNER_W     (OW),
    .GNT_TIMEOUT (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_frame       (frame),
    .i_irdy        (irdy),
    .o_gnt         (gnt),
    .o_owner       (owner),
    .o_owner_valid (owner_valid),
    .o_timeout_stb (timeout_stb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_valid;     // some master owns the bus or holds a grant
  bit m_gnt_on;    // that master's GNT# is currently asserted
  bit m_in_xfer;   // that master has started a transaction
  bit m_stb;
  int m_owner;
  int m_last;
  int m_cnt;

  function automatic int pick_winner(logic [NM-1:0] r, int last);
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last + k) % NM;
      if (!r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] model_gnt();
    logic [NM-1:0] one;
    one = NM'(1);
    return m_gnt_on ? ~(one << m_owner) : '1;
  endfunction

  // Applies the arbitration rules to the inputs present just before an edge.
  task automatic model_edge();
    bit            bidle;
    bit            others;
    int            w;
    logic [NM-1:0] one;
    one    = NM'(1);
    bidle  = frame && irdy;
    m_stb  = 1'b0;
    if (rst) begin
      m_valid = 0; m_gnt_on = 0; m_in_xfer = 0;
      m_owner = 0; m_last = NM - 1; m_cnt = 0;
    end else if (!m_valid) begin
      w = pick_winner(req, m_last);
      if (w >= 0) begin
        m_valid = 1; m_gnt_on = 1; m_in_xfer = 0;
        m_owner = w; m_last = w; m_cnt = 0;
      end
    end else if (!m_in_xfer) begin
      if (!frame) m_in_xfer = 1;
      else if (req[m_owner]) begin
        m_valid = 0; m_gnt_on = 0;
      end
`ifdef PCI_ARB_GNT_TIMEOUT_EN
      else if (m_cnt == TMO) begin
        m_valid = 0; m_gnt_on = 0; m_stb = 1; m_last = m_owner;
      end else if (bidle) m_cnt++;
`endif
    end else begin
      others = ((~req) & ~(one << m_owner)) != '0;
      if (bidle) begin
        if (m_gnt_on && !req[m_owner] && !others) begin
          m_in_xfer = 0; m_cnt = 0;
        end else begin
          m_valid = 0; m_gnt_on = 0; m_in_xfer = 0;
        end
      end else if (m_gnt_on && (others || req[m_owner])) begin
        m_gnt_on = 0;
      end
    end
  endtask

  // One clock: advance the model, then let the DUT take the same edge and
  // settle before anything is sampled.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '1; frame = 1'b1; irdy = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; req = '1; frame = 1'b1; irdy = 1'b1;
    step(); step();
    n_cmp++;
    if ({gnt, owner_valid, owner, timeout_stb} !== {4'b1111, 1'b0, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got gnt=%b v=%b own=%0d stb=%b, want gnt=1111 v=0 own=0 stb=0",
               gnt, owner_valid, owner, timeout_stb);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({gnt, owner_valid} !== {4'b1111, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_no_req: got gnt=%b v=%b, want gnt=1111 v=0", gnt, owner_valid);
    end
  endtask

  task automatic test_single_master();
    do_reset();
    req = 4'b1110;
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1110, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b v=%b own=%0d, want gnt=1110 v=1 own=0",
               gnt, owner_valid, owner);
    end
    step();
    frame = 1'b0;
    step();                       // GRANT -> BUSY
    irdy = 1'b0;
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1110, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL single_busy: got gnt=%b v=%b own=%0d, want gnt=1110 v=1 own=0",
               gnt, owner_valid, owner);
    end
    frame = 1'b1; irdy = 1'b1;
    step();                       // BIDLE, REQ held -> back to GRANT
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1110, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL single_back_to_back: got gnt=%b v=%b own=%0d, want gnt=1110 v=1 own=0",
               gnt, owner_valid, owner);
    end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g;
    do_reset();
    req = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      exp_g = ~(NM'(1) << (g % NM));
      frame = 1'b1; irdy = 1'b1;
      step();                     // grant issued from IDLE
      n_cmp++;
      if ({gnt, owner} !== {exp_g, OW'(g % NM)}) begin
        n_bad++;
        $display("FAIL rr_grant_%0d: got gnt=%b own=%0d, want gnt=%b own=%0d",
                 g, gnt, owner, exp_g, g % NM);
      end
      frame = 1'b0;
      step();                     // transaction starts
      step();                     // competitors present -> grant removed
      n_cmp++;
      if ({gnt, owner_valid} !== {4'b1111, 1'b1}) begin
        n_bad++;
        $display("FAIL rr_preempt_%0d: got gnt=%b v=%b, want gnt=1111 v=1",
                 g, gnt, owner_valid);
      end
      frame = 1'b1;
      step();                     // bus idle -> IDLE
      n_cmp++;
      if ({gnt, owner_valid} !== {4'b1111, 1'b0}) begin
        n_bad++;
        $display("FAIL rr_gap_%0d: got gnt=%b v=%b, want gnt=1111 v=0",
                 g, gnt, owner_valid);
      end
    end
  endtask

  task automatic test_preemption();
    do_reset();
    req = 4'b1101;
    step();
    frame = 1'b0;
    step();
    irdy = 1'b0;
    step();
    n_cmp++;
    if ({gnt, owner} !== {4'b1101, 2'd1}) begin
      n_bad++;
      $display("FAIL preempt_owner: got gnt=%b own=%0d, want gnt=1101 own=1", gnt, owner);
    end
    req = 4'b0101;                // master 3 joins while master 1 is busy
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1111, 1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL preempt_revoke: got gnt=%b v=%b own=%0d, want gnt=1111 v=1 own=1",
               gnt, owner_valid, owner);
    end
    frame = 1'b1; irdy = 1'b1;
    step();
    n_cmp++;
    if ({gnt, owner_valid} !== {4'b1111, 1'b0}) begin
      n_bad++;
      $display("FAIL preempt_idle: got gnt=%b v=%b, want gnt=1111 v=0", gnt, owner_valid);
    end
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b0111, 1'b1, 2'd3}) begin
      n_bad++;
      $display("FAIL preempt_next: got gnt=%b v=%b own=%0d, want gnt=0111 v=1 own=3",
               gnt, owner_valid, owner);
    end
  endtask

  task automatic test_withdrawal();
    do_reset();
    req = 4'b1011;
    step();
    n_cmp++;
    if ({gnt, owner} !== {4'b1011, 2'd2}) begin
      n_bad++;
      $display("FAIL withdraw_grant: got gnt=%b own=%0d, want gnt=1011 own=2", gnt, owner);
    end
    req = 4'b1111;
    step();
    n_cmp++;
    if ({gnt, owner_valid} !== {4'b1111, 1'b0}) begin
      n_bad++;
      $display("FAIL withdraw_drop: got gnt=%b v=%b, want gnt=1111 v=0", gnt, owner_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 4'b1110;
    step();
    frame = 1'b0;
    step();                       // BUSY
    rst = 1'b1;
    step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1111, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_busy: got gnt=%b v=%b own=%0d, want gnt=1111 v=0 own=0",
               gnt, owner_valid, owner);
    end
    rst = 1'b0; frame = 1'b1; irdy = 1'b1; req = 4'b0000;
    step();
    n_cmp++;
    if ({gnt, owner} !== {4'b1110, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_first_winner: got gnt=%b own=%0d, want gnt=1110 own=0", gnt, owner);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1101;
    step();                       // master 1 granted, bus left idle
`ifdef PCI_ARB_GNT_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      step();
      n_cmp++;
      if ({gnt, timeout_stb} !== {4'b1101, 1'b0}) begin
        n_bad++;
        $display("FAIL tmo_hold_%0d: got gnt=%b stb=%b, want gnt=1101 stb=0", i, gnt, timeout_stb);
      end
    end
    step();
    n_cmp++;
    if ({gnt, owner_valid, timeout_stb} !== {4'b1111, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL tmo_revoke: got gnt=%b v=%b stb=%b, want gnt=1111 v=0 stb=1",
               gnt, owner_valid, timeout_stb);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if ({gnt, owner, timeout_stb} !== {4'b1011, 2'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_next: got gnt=%b own=%0d stb=%b, want gnt=1011 own=2 stb=0",
               gnt, owner, timeout_stb);
    end
`else
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++;
      if ({gnt, timeout_stb} !== {4'b1101, 1'b0}) begin
        n_bad++;
        $display("FAIL park_hold_%0d: got gnt=%b stb=%b, want gnt=1101 stb=0", i, gnt, timeout_stb);
      end
    end
    // Other requesters cannot pull an unused grant away without a timeout.
    req = 4'b0000;
    step(); step();
    n_cmp++;
    if ({gnt, owner_valid, owner} !== {4'b1101, 1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL park_contested: got gnt=%b v=%b own=%0d, want gnt=1101 v=1 own=1",
               gnt, owner_valid, owner);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic against the model
  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [NM-1:0] prev_g;
    logic [NM-1:0] exp_g;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0:       req = NM'($urandom);
        1:       req = NM'($urandom) | NM'($urandom);
        default: req = req;       // hold, letting transactions complete
      endcase
      frame  = ($urandom_range(0, 2) != 0);
      irdy   = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      prev_g = gnt;
      step();
      exp_g = model_gnt();
      n_cmp++;
      if ({gnt, owner_valid, timeout_stb} !== {exp_g, m_valid, m_stb}) begin
        n_bad++;
        $display("FAIL rand_cyc%0d: got gnt=%b v=%b stb=%b, want gnt=%b v=%b stb=%b",
                 c, gnt, owner_valid, timeout_stb, exp_g, m_valid, m_stb);
      end
      if (m_valid) begin
        n_cmp++;
        if (owner !== OW'(m_owner)) begin
          n_bad++;
          $display("FAIL rand_owner_cyc%0d: got own=%0d, want own=%0d", c, owner, m_owner);
        end
      end
      n_cmp++;
      if ($countones(~gnt) > 1) begin
        n_bad++;
        $display("FAIL rand_onehot_cyc%0d: got gnt=%b, want at most one low bit", c, gnt);
      end
      n_cmp++;
      if (prev_g != '1 && gnt != '1 && gnt != prev_g) begin
        n_bad++;
        $display("FAIL rand_gap_cyc%0d: got gnt %b -> %b, want an all-1 cycle between owners",
                 c, prev_g, gnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '1; frame = 1'b1; irdy = 1'b1;
    test_reset();
    test_single_master();
    test_round_robin();
    test_preemption();
    test_withdrawal();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
Name: pci_arbiter

Overview:
- Central PCI bus arbiter for the device bench and system top.
- Shares the single AD/CBE/FRAME/IRDY bus among NUM_MASTERS initiators using active-low REQ/GNT pairs.
- Arbitration is round-robin.
- Watches FRAME and IRDY to track bus ownership and to time grant hand-over, so grants never overlap and every hand-over has an idle gap.

Parameters:
- NUM_MASTERS, 4, number of REQ/GNT pairs; legal range 2..8.
- OWNER_W, 2, width of OWNER index; must be >= clog2(NUM_MASTERS).
- GNT_TIMEOUT, 16, idle-bus cycles a granted master may take to assert FRAME; used only with the optional feature.

Ports:
- CLK  input  1  bus clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NUM_MASTERS  per-master request, active-low; bit i belongs to master i.
- FRAME  input  1  PCI FRAME#, active-low; driven by the current initiator.
- IRDY  input  1  PCI IRDY#, active-low.
- GNT  output  NUM_MASTERS  per-master grant, active-low; at most one bit is 0 at any time.
- OWNER  output  OWNER_W  index of the currently granted or owning master.
- OWNER_VALID  output  1  high when OWNER is meaningful (GRANT or BUSY state).
- TIMEOUT_STB  output  1  one-cycle pulse when a grant is revoked for non-use.

Behaviour:
- Reset:
  - Takes effect on any edge where RST=1, including mid-transaction.
  - state=IDLE, GNT all 1, OWNER=0, OWNER_VALID=0, TIMEOUT_STB=0.
  - LAST=NUM_MASTERS-1, so master 0 has highest priority first.
- Bus idle (BIDLE): FRAME=1 and IRDY=1, both as sampled on the edge.
- Winner selection:
  - Search for the first i with REQ[i]=0, starting at LAST+1 and wrapping modulo NUM_MASTERS.
  - LAST updates to the winner whenever a grant is issued.
- All outputs are registered.
- States:
  - IDLE: GNT all 1.
    - Any REQ low at edge k: GNT[W]=0, OWNER=W, OWNER_VALID=1 from edge k, go to GRANT. Grant latency is 1 clock.
    - No request: stay in IDLE.
  - GRANT: GNT[OWNER]=0.
    - FRAME=0 sampled: go to BUSY.
    - Else if REQ[OWNER]=1 (request withdrawn): GNT all 1, OWNER_VALID=0, go to IDLE.
    - Else stay in GRANT.
  - BUSY: the owner's transaction is in progress.
    - If another REQ[j]=0 (j != OWNER), or REQ[OWNER]=1, while GNT[OWNER]=0: drive GNT all 1 at the next edge. OWNER and OWNER_VALID are held; the owner finishes its current transaction.
    - On BIDLE with GNT[OWNER] still 0 and REQ[OWNER]=0: go to GRANT, same owner (back-to-back transfers).
    - On BIDLE otherwise: GNT all 1, OWNER_VALID=0, go to IDLE.
- Hand-over rule:
  - Moving the grant between different masters always passes through at least one edge with GNT all 1.
  - A new GNT is never asserted in the same cycle another is removed.
- Simultaneous events:
  - In GRANT, FRAME=0 takes precedence over request withdrawal.
  - In BUSY, BIDLE together with a competing request goes to IDLE, and the next winner is granted one cycle later.
- Single-requester rule: a lone requester keeps its grant indefinitely while REQ stays low (bus parking on the active master).
- REQ bits at index >= NUM_MASTERS do not exist; no X handling is required beyond reset.

Optional Feature:
- Macro: PCI_ARB_GNT_TIMEOUT_EN.
- Defined:
  - In GRANT, a counter increments on each edge where BIDLE=1; it clears when entering GRANT.
  - When the count reaches GNT_TIMEOUT, at the next edge: GNT all 1, OWNER_VALID=0, TIMEOUT_STB=1 for one cycle, go to IDLE.
  - LAST=OWNER, so the offending master drops to lowest priority.
- Not defined: no counter; TIMEOUT_STB is tied to 0; a master may hold GRANT indefinitely without using the bus.

Test Plan:
1. Single master, NUM_MASTERS=4: REQ=4'b1110 at edge 1 -> GNT=4'b1110, OWNER=0, OWNER_VALID=1 after edge 1. FRAME=0 at edge 3 -> BUSY. FRAME/IRDY return to 1 with REQ held -> back to GRANT, GNT unchanged.
2. Round-robin: REQ=4'b0000 held, each master runs one FRAME transaction per grant -> grant order 0,1,2,3,0. At least one all-1 GNT cycle between grants.
3. Preemption: master 1 in BUSY, master 3 asserts REQ -> GNT=4'b1111 on the next edge while FRAME=0. On BIDLE, IDLE, then GNT=4'b0111 one edge later.
4. Withdrawal: master 2 granted, REQ[2] deasserted before FRAME -> GNT=4'b1111, OWNER_VALID=0 next edge, no transaction.
5. Reset mid-BUSY: RST=1 for one edge with FRAME=0 -> GNT=4'b1111, OWNER_VALID=0 immediately. With REQ=4'b0000 after reset, master 0 is granted first.
6. With PCI_ARB_GNT_TIMEOUT_EN: master 1 granted, bus idle, FRAME never asserted -> after 16 idle edges GNT=4'b1111 and TIMEOUT_STB pulses once. With REQ=4'b0000 the next grant goes to master 2.
